// File: rtl/gf_sram_arbiter_if.sv
// Fabric-side request/response bundle for gf_sram_arbiter.
// Two requesters share one bus. The master side drives the requests and the
// arbiter (slave) returns the grants, read strobes, read data and busy.
interface gf_sram_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 8
) ();
    logic [1:0]    req;
    logic [1:0]    we;
    logic [DW-1:0] wmask0;
    logic [DW-1:0] wmask1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          busy;

    modport master (
        output req, we, wmask0, wmask1, addr0, addr1, wdata0, wdata1,
        input  gnt, rvalid, rdata, busy
    );

    modport slave (
        input  req, we, wmask0, wmask1, addr0, addr1, wdata0, wdata1,
        output gnt, rvalid, rdata, busy
    );
endinterface

// File: rtl/gf_sram_arbiter.sv
// Two-requester round-robin controller for a single-port GF SRAM macro.
// Accepts at most one access per cycle, drives registered macro pins and
// returns read data a fixed two cycles after the grant edge.
// Optional feature macro: GF_SRAM_ARB_CLEAR_EN adds a post-reset sweep that
// writes zero to every address before fabric traffic is accepted.
module gf_sram_arbiter #(
    parameter int AW    = 9,
    parameter int DW    = 8,
    parameter int RDLAT = 2   // only 2 matches the macro timing
) (
    input  logic          UserCLK,
    input  logic          rst,
    gf_sram_arbiter_if.slave bus,
    output logic          CEN_SRAM,
    output logic          GWEN_SRAM,
    output logic [DW-1:0] WEN_SRAM,
    output logic [AW-1:0] A_SRAM,
    output logic [DW-1:0] D_SRAM,
    input  logic [DW-1:0] Q_SRAM,
    output logic          CLK_SRAM
);

`ifdef GF_SRAM_ARB_CLEAR_EN
    typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;
    // One bit wider than the address so the sweep end and the guard cycle
    // after it can be told apart without a second flag.
    logic [AW:0] clr_cnt;
`else
    typedef enum logic [0:0] {ST_RESET, ST_RUN} state_t;
`endif

    state_t                 state;
    logic                   rr_last;       // index of the most recent grant
    logic [1:0]             gnt;
    logic [1:0]             rd_issue;
    logic [RDLAT-1:0][1:0]  rd_pipe;       // per-port read tags in flight
    logic [1:0]             rvalid_q;
    logic [DW-1:0]          rdata_q;
    logic                   sel_we;
    logic [DW-1:0]          sel_mask;
    logic [AW-1:0]          sel_addr;
    logic [DW-1:0]          sel_data;

    assign CLK_SRAM   = UserCLK;
    assign bus.busy   = (state != ST_RUN);
    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_q;
    assign rd_issue   = gnt & ~bus.we;

    // Round-robin grant: a lone requester wins, a tie goes to the port that
    // did not win last. Gated by rst so no request is accepted and then lost.
    always_comb begin
        // NOTE: defaults first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (state == ST_RUN && !rst) begin
            gnt[0] = bus.req[0] & (~bus.req[1] | rr_last);
            gnt[1] = bus.req[1] & (~bus.req[0] | ~rr_last);
        end
    end

    // Select the granted port's access fields.
    always_comb begin
        sel_we   = bus.we[0];
        sel_mask = bus.wmask0;
        sel_addr = bus.addr0;
        sel_data = bus.wdata0;
        if (gnt[1]) begin
            sel_we   = bus.we[1];
            sel_mask = bus.wmask1;
            sel_addr = bus.addr1;
            sel_data = bus.wdata1;
        end
    end

    // Control FSM, macro pin registers and read-return pipeline.
    always_ff @(posedge UserCLK) begin
        if (rst) begin
            // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
            state     <= ST_RESET;
            rr_last   <= 1'b1;
            CEN_SRAM  <= 1'b1;
            GWEN_SRAM <= 1'b1;
            WEN_SRAM  <= '1;
            A_SRAM    <= '0;
            D_SRAM    <= '0;
            rd_pipe   <= '0;
            rvalid_q  <= 2'b00;
            rdata_q   <= '0;
`ifdef GF_SRAM_ARB_CLEAR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            // Idle pins unless an access is issued below; A and D hold.
            CEN_SRAM  <= 1'b1;
            GWEN_SRAM <= 1'b1;
            WEN_SRAM  <= '1;

            // The macro returns Q one edge after it samples the read, so the
            // tag is captured alongside Q two edges after the grant.
            rd_pipe  <= {rd_pipe[RDLAT-2:0], rd_issue};
            rvalid_q <= rd_pipe[RDLAT-1];
            if (|rd_pipe[RDLAT-1]) begin
                rdata_q <= Q_SRAM;
            end

            case (state)
                ST_RESET: begin
`ifdef GF_SRAM_ARB_CLEAR_EN
                    state     <= ST_CLEAR;
                    CEN_SRAM  <= 1'b0;
                    GWEN_SRAM <= 1'b0;
                    WEN_SRAM  <= '0;
                    A_SRAM    <= '0;
                    D_SRAM    <= '0;
                    clr_cnt   <= {{AW{1'b0}}, 1'b1};
`else
                    state     <= ST_RUN;
`endif
                end
`ifdef GF_SRAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    if (!clr_cnt[AW]) begin
                        CEN_SRAM  <= 1'b0;
                        GWEN_SRAM <= 1'b0;
                        WEN_SRAM  <= '0;
                        A_SRAM    <= clr_cnt[AW-1:0];
                        D_SRAM    <= '0;
                        clr_cnt   <= clr_cnt + 1'b1;
                    end else if (!clr_cnt[0]) begin
                        // One guard cycle after the last clear write.
                        clr_cnt <= clr_cnt + 1'b1;
                    end else begin
                        state <= ST_RUN;
                    end
                end
`endif
                ST_RUN: begin
                    if (|gnt) begin
                        rr_last   <= gnt[1];
                        CEN_SRAM  <= 1'b0;
                        GWEN_SRAM <= ~sel_we;
                        WEN_SRAM  <= ~sel_mask;
                        A_SRAM    <= sel_addr;
                        D_SRAM    <= sel_data;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_sram_arbiter.sv
// Directed bench for gf_sram_arbiter with a behavioural model of the
// 512x8 single-port macro attached to the pin interface.
`timescale 1ns/1ps
module tb_gf_sram_arbiter;
    localparam int AW = 9;
    localparam int DW = 8;

`ifdef GF_SRAM_ARB_CLEAR_EN
    localparam logic [DW-1:0] E055 = 8'h00;
    localparam logic [DW-1:0] E003 = 8'h00;
`else
    localparam logic [DW-1:0] E055 = 8'hA5;
    localparam logic [DW-1:0] E003 = 8'hF0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen, gwen, clk_sram;
    logic [DW-1:0] wen, d, q;
    logic [AW-1:0] a;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    gf_sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    gf_sram_arbiter #(.AW(AW), .DW(DW), .RDLAT(2)) dut (
        .UserCLK   (clk),
        .rst       (rst),
        .bus       (bus),
        .CEN_SRAM  (cen),
        .GWEN_SRAM (gwen),
        .WEN_SRAM  (wen),
        .A_SRAM    (a),
        .D_SRAM    (d),
        .Q_SRAM    (q),
        .CLK_SRAM  (clk_sram)
    );

    // Macro model: bit-masked write, registered read data that holds.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk_sram) begin
        if (!cen) begin
            if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
            else       q      <= mem[a];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 600 && bus.busy; i++) step();
        check("ready", bus.busy, 1'b0);
    endtask

    // Present one port-0 access, confirm the grant, let the grant edge pass.
    task automatic issue0(input logic w, input logic [AW-1:0] ad,
                          input logic [DW-1:0] dt, input logic [DW-1:0] mk, input string tag);
        bus.we[0]  = w;
        bus.addr0  = ad;
        bus.wdata0 = dt;
        bus.wmask0 = mk;
        bus.req    = 2'b01;
        #1;
        check(tag, bus.gnt, 2'b01);
        step();
        bus.req = 2'b00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g_exp [4];
        int         busy_n;
        logic       gnt_seen;
        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

        bus.req = '0; bus.we = '0;
        bus.wmask0 = '0; bus.wmask1 = '0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset state
        rst = 1'b1;
        step(); step();
        check("rst_cen", cen, 1'b1);
        check("rst_gwen", gwen, 1'b1);
        check("rst_wen", wen, 8'hFF);
        check("rst_a", a, 9'h000);
        check("rst_d", d, 8'h00);
        check("rst_rvalid", bus.rvalid, 2'b00);
        check("rst_rdata", bus.rdata, 8'h00);
        check("rst_busy", bus.busy, 1'b1);
        bus.req = 2'b11;
        #1;
        check("rst_gnt", bus.gnt, 2'b00);
        bus.req = 2'b00;
        rst = 1'b0;
        check("reset_state_busy", bus.busy, 1'b1);
        wait_ready();

        // T1 write then read
        issue0(1'b1, 9'h055, 8'hA5, 8'hFF, "t1_wr_gnt");
        check("t1_cen", cen, 1'b0);
        check("t1_gwen", gwen, 1'b0);
        check("t1_wen", wen, 8'h00);
        check("t1_a", a, 9'h055);
        check("t1_d", d, 8'hA5);
        issue0(1'b0, 9'h055, 8'h00, 8'h00, "t1_rd_gnt");
        check("t1_rd_cen", cen, 1'b0);
        check("t1_rd_gwen", gwen, 1'b1);
        step();
        check("t1_rv_early", bus.rvalid, 2'b00);
        step();
        check("t1_rvalid", bus.rvalid, 2'b01);
        check("t1_rdata", bus.rdata, 8'hA5);
        step();
        check("t1_rv_late", bus.rvalid, 2'b00);
        check("t1_rdata_hold", bus.rdata, 8'hA5);

        // T3 bit mask, plus an all-zero mask write
        issue0(1'b1, 9'h003, 8'hFF, 8'hFF, "t3_w1");
        issue0(1'b1, 9'h003, 8'h00, 8'h0F, "t3_w2");
        check("t3_wen", wen, 8'hF0);
        check("t3_gwen", gwen, 1'b0);
        issue0(1'b1, 9'h003, 8'h00, 8'h00, "t3_w0");
        check("t3_w0_cen", cen, 1'b0);
        check("t3_w0_gwen", gwen, 1'b0);
        check("t3_w0_wen", wen, 8'hFF);
        issue0(1'b0, 9'h003, 8'h00, 8'h00, "t3_rd");
        step(); step();
        check("t3_rvalid", bus.rvalid, 2'b01);
        check("t3_rdata", bus.rdata, 8'hF0);

        // T2 contention from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready();
        bus.we = 2'b00;
        bus.addr0 = 9'h055;
        bus.addr1 = 9'h003;
        bus.wdata1 = 8'h00;
        for (int j = 0; j < 8; j++) begin
            bus.req = (j < 4) ? 2'b11 : 2'b00;
            #1;
            check($sformatf("t2_gnt%0d", j), bus.gnt, (j < 4) ? g_exp[j] : 2'b00);
            if (j >= 3 && j < 7) begin
                check($sformatf("t2_rv%0d", j), bus.rvalid, g_exp[j-3]);
                check($sformatf("t2_rd%0d", j), bus.rdata, (g_exp[j-3] == 2'b01) ? E055 : E003);
            end else begin
                check($sformatf("t2_rv%0d", j), bus.rvalid, 2'b00);
            end
            step();
        end

        // T6 idle: no activity, pins hold, rr_last keeps port 1 as last winner
        for (int k = 0; k < 10; k++) begin
            check($sformatf("t6_cen%0d", k), cen, 1'b1);
            check($sformatf("t6_rv%0d", k), bus.rvalid, 2'b00);
            step();
        end
        check("t6_a_hold", a, 9'h003);
        bus.req = 2'b11;
        #1;
        check("t6_rr", bus.gnt, 2'b01);
        bus.req = 2'b00;
        for (int k = 0; k < 4; k++) step();

        // T5 reset mid-read
        issue0(1'b0, 9'h055, 8'h00, 8'h00, "t5_gnt");
        rst = 1'b1;
        step();
        check("t5_cen", cen, 1'b1);
        check("t5_wen", wen, 8'hFF);
        check("t5_busy", bus.busy, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t5_rv%0d", k), bus.rvalid, 2'b00);
            step();
        end
        wait_ready();

`ifdef GF_SRAM_ARB_CLEAR_EN
        // T4 clear sweep
        issue0(1'b1, 9'h1FF, 8'h3C, 8'hFF, "t4_w");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.we[0] = 1'b0;
        bus.addr0 = 9'h1FF;
        bus.req   = 2'b01;
        busy_n   = 0;
        gnt_seen = 1'b0;
        for (int i = 0; i < 600 && bus.busy; i++) begin
            #1;
            if (bus.gnt != 2'b00) gnt_seen = 1'b1;
            busy_n++;
            step();
        end
        check("t4_busy_cycles", busy_n, 514);
        check("t4_no_gnt", gnt_seen, 1'b0);
        #1;
        check("t4_gnt", bus.gnt, 2'b01);
        step();
        bus.req = 2'b00;
        step(); step();
        check("t4_rvalid", bus.rvalid, 2'b01);
        check("t4_rdata", bus.rdata, 8'h00);
`else
        busy_n   = 0;
        gnt_seen = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
